// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier, signed or unsigned operands.
// One Booth step per clock; fixed latency of WIDTH+1 steps after accept.
//
// Handshake: start is a request sampled only in IDLE; the edge that sees
// start=1 in IDLE accepts a, b and sgn. busy is high from the accept edge
// until the return to IDLE. done is a one-cycle pulse in the cycle where z
// first carries the new product; z then holds until the next result.
module booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          sgn,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  output logic [2*WIDTH-1:0]            z,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(WIDTH+2)-1:0]    iter
);

  localparam int CW = $clog2(WIDTH+2);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Multiplicand kept at WIDTH+2 bits so add/subtract cannot overflow
  // before the arithmetic shift; multiplier extended to WIDTH+1 bits.
  logic [WIDTH+1:0] mcand;
  logic [WIDTH+1:0] acc;
  logic [WIDTH:0]   q;
  logic             qm1;

  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] acc_nxt;
  logic [WIDTH:0]   q_nxt;
  logic [2*WIDTH-1:0] prod_lo;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (iter == LAST_STEP) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // One Booth step: add/subtract by the {q0, q(-1)} pair, then shift right
  always_comb begin
    sum = acc;
    case ({q[0], qm1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
    acc_nxt = {sum[WIDTH+1], sum[WIDTH+1:1]};
    q_nxt   = {sum[0], q[WIDTH:1]};
    prod_lo = {acc_nxt[WIDTH-2:0], q_nxt};
  end

  // Operand, accumulator, counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      q     <= '0;
      qm1   <= 1'b0;
      iter  <= '0;
      z     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= sgn ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
            q     <= {sgn & b[WIDTH-1], b};
            acc   <= '0;
            qm1   <= 1'b0;
            iter  <= '0;
          end
        end
        RUN: begin
          acc  <= acc_nxt;
          q    <= q_nxt;
          qm1  <= q[0];
          iter <= iter + 1'b1;
          if (iter == LAST_STEP) z <= prod_lo;
        end
        DONE: begin
          iter <= '0;
        end
        default: begin
          iter <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and random checks of booth_seq_mult (WIDTH=8) against a plain
// arithmetic product model.
module tb_booth_seq_mult;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] z;
  logic        busy;
  logic        done;
  logic [3:0]  iter;

  int n_checks = 0;
  int n_fail   = 0;

  booth_seq_mult #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sgn   (sgn),
    .a     (a),
    .b     (b),
    .z     (z),
    .busy  (busy),
    .done  (done),
    .iter  (iter)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product: exact integer product truncated to 16 bits
  function automatic logic [15:0] ref_prod(input logic s, input logic [7:0] x, input logic [7:0] y);
    longint px;
    longint py;
    longint p;
    if (s) begin
      px = $signed(x);
      py = $signed(y);
    end else begin
      px = $signed({1'b0, x});
      py = $signed({1'b0, y});
    end
    p = px * py;
    return p[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: launches one multiply and checks the whole run.
  // With scramble set, inputs and start are randomised throughout RUN.
  task automatic run_op(input string tag, input logic s, input logic [7:0] x,
                        input logic [7:0] y, input bit scramble);
    logic [15:0] exp_z;
    int n;
    int busy_cnt;
    exp_z = ref_prod(s, x, y);
    sgn   = s;
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    n = 0;
    while (n < 40) begin
      if (busy) busy_cnt++;
      if (done) break;
      if (scramble) begin
        a     = 8'($urandom);
        b     = 8'($urandom);
        sgn   = 1'($urandom);
        start = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, n, 9);
    chk({tag, "_z"}, z, exp_z);
    chk({tag, "_iter_done"}, iter, 9);
    chk({tag, "_busy_cycles"}, busy_cnt, 10);
    a = 8'($urandom);
    b = 8'($urandom);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_iter"}, iter, 0);
    chk({tag, "_z_hold"}, z, exp_z);
  endtask

  initial begin
    int n;
    int t;
    int done_times[$];
    bit extra_done;

    rst   = 1'b1;
    start = 1'b0;
    sgn   = 1'b0;
    a     = 8'd0;
    b     = 8'd0;

    // Reset state
    #1;
    chk("rst_z", z, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_iter", iter, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed corners
    run_op("uns_ones", 1'b0, 8'hFF, 8'hFF, 1'b0);
    chk("uns_ones_const", z, 16'hFE01);
    run_op("sgn_ones", 1'b1, 8'hFF, 8'hFF, 1'b0);
    chk("sgn_ones_const", z, 16'h0001);
    run_op("sgn_minmin", 1'b1, 8'h80, 8'h80, 1'b0);
    chk("sgn_minmin_const", z, 16'h4000);
    run_op("sgn_maxmin", 1'b1, 8'h7F, 8'h80, 1'b0);
    chk("sgn_maxmin_const", z, 16'hC080);
    run_op("zero", 1'b1, 8'h00, 8'h93, 1'b0);
    run_op("uns_min", 1'b0, 8'h80, 8'hFF, 1'b0);

    // Inputs and start toggled during RUN
    run_op("scramble", 1'b0, 8'd3, 8'd5, 1'b1);
    chk("scramble_const", z, 16'h000F);
    extra_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) extra_done = 1'b1;
      @(negedge clk);
    end
    chk("scramble_single_done", extra_done, 0);

    // Reset in the middle of a run
    sgn = 1'b0; a = 8'd77; b = 8'd91; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (iter != 4'd4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reach_iter4", iter, 4);
    #2 rst = 1'b1;
    #1;
    chk("midrst_z", z, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_iter", iter, 0);
    extra_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      if (done || busy) extra_done = 1'b1;
    end
    chk("midrst_no_done", extra_done, 0);
    run_op("after_rst", 1'b0, 8'd2, 8'd2, 1'b0);
    chk("after_rst_const", z, 16'h0004);

    // Start applied on the very edge that follows reset release
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_op("rst_release_start", 1'b1, 8'hC3, 8'h25, 1'b0);

    // Randomised operands
    for (int i = 0; i < 24; i++) begin
      run_op("rand", 1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    end

    // Back-to-back with start held high
    sgn = 1'b0; a = 8'd10; b = 8'd20; start = 1'b1;
    t = 0;
    while (done_times.size() < 3 && t < 80) begin
      @(negedge clk);
      t++;
      if (done) begin
        done_times.push_back(t);
        chk("b2b_z", z, 16'h00C8);
      end
    end
    start = 1'b0;
    chk("b2b_count", done_times.size(), 3);
    if (done_times.size() == 3) begin
      chk("b2b_period1", done_times[1] - done_times[0], 11);
      chk("b2b_period2", done_times[2] - done_times[1], 11);
    end
    for (int i = 0; i < 12; i++) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
